pipe_latch_skid: RTL and testbench

- Parametrised successor to the fixed IF/ID latch: a generic pipeline-stage register carrying an instruction word and its PC+4 between two stages.
- Adds valid/ready handshaking, a one-entry skid buffer for full throughput under back-pressure, and NOP bubble insertion.
- Keeps the hazard unit's hold and flush controls: hold is active-high, 1 = hold; flush is a synchronous clear.
- Instantiated between each pair of pipeline stages (IF/ID, ID/EX, ...) with per-stage widths.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_sat_counter.sv | 16 +
 rtl/pipe_latch_skid.sv | 75 +++++++
 tb/tb_pipe_latch_skid.sv | 134 +++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and entry type for the pipeline stage latches.
package pipe_pkg;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_PC_W = 32;
  localparam int DEF_CNT_W = 16;
  localparam logic [31:0] NOP_INSTR_DEF = 32'hFC000000;
  typedef struct packed {
    logic valid;
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_PC_W-1:0] pc;
  } pipe_entry_t;
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: enabled up-counter that sticks at all-ones, async active-high reset.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = (en && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/pipe_latch_skid.sv
// pipe_latch_skid: valid/ready pipeline register with one-entry skid buffer, hold, flush and NOP bubbles.
// Define PIPE_SKID_STATS_EN to add saturating bubble_cnt / flush_cnt statistics ports.
module pipe_latch_skid
  import pipe_pkg::*;
#(
  parameter int          INSTR_W   = DEF_INSTR_W,
  parameter int          PC_W      = DEF_PC_W,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter int          CNT_W     = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               hold,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   flush_cnt
`endif
);
  typedef struct packed {
    logic valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0] pc;
  } entry_t;
  localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(NOP_INSTR);
  if (CNT_W < 1) $error("CNT_W must be positive");
  entry_t main_q, main_d, skid_q, skid_d, in_e;
  logic acc, adv;
  assign in_e = '{valid: 1'b1, instr: in_instr, pc: in_pc};
  assign in_ready = !skid_q.valid;
  assign acc = in_valid && in_ready;
  assign adv = main_q.valid && out_ready && !hold;
  assign out_valid = main_q.valid;
  assign out_instr = main_q.valid ? main_q.instr : NOP_W;
  assign out_pc = main_q.valid ? main_q.pc : '0;
  // Skid only ever holds a beat while main is full, so main refills from skid first.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      main_d = '0;
      skid_d = '0;
    end else if (!main_q.valid || adv) begin
      main_d = skid_q.valid ? skid_q : (acc ? in_e : '0);
      skid_d = (skid_q.valid && acc) ? in_e : '0;
    end else if (acc) begin
      skid_d = in_e;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
`ifdef PIPE_SKID_STATS_EN
  pipe_sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk(clk), .rst(rst), .en(!main_q.valid && !hold), .cnt(bubble_cnt)
  );
  pipe_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .en(flush), .cnt(flush_cnt)
  );
`endif
endmodule

// File: tb/tb_pipe_latch_skid.sv
// tb_pipe_latch_skid: directed stimulus against a two-deep FIFO model of the stage, plus literal spot checks.
module tb_pipe_latch_skid;
  logic clk = 0, rst = 1, flush = 0, hold = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_instr = 0, in_pc = 0, out_instr, out_pc;
  logic in_ready, out_valid;
  int n_cmp = 0, n_bad = 0;
  logic [63:0] q[$];
`ifdef PIPE_SKID_STATS_EN
  logic [1:0] bubble_cnt, flush_cnt;
`endif

  pipe_latch_skid #(
`ifdef PIPE_SKID_STATS_EN
    .CNT_W(2)
`else
    .CNT_W(16)
`endif
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
`ifdef PIPE_SKID_STATS_EN
    , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the stage behaves as a FIFO of depth two whose head is the output.
  always @(posedge clk or posedge rst) begin
    if (rst) q.delete();
    else if (flush) q.delete();
    else begin
      automatic bit acc = in_valid && q.size() < 2;
      automatic bit adv = q.size() > 0 && out_ready && !hold;
      if (adv) void'(q.pop_front());
      if (acc) q.push_back({in_instr, in_pc});
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_instr", 64'(out_instr), q.size() > 0 ? 64'(q[0][63:32]) : 64'h0FC000000);
    chk("out_pc", 64'(out_pc), q.size() > 0 ? 64'(q[0][31:0]) : 64'h0);
  end

  task automatic tick(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic hld, input logic fl);
    @(negedge clk);
    in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; hold = hld; flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #23 rst = 0;
`ifdef PIPE_SKID_STATS_EN
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 1, 0, 0);
    chk("bubble_sat", 64'(bubble_cnt), 64'd3);
    tick(0, 0, 0, 1, 0, 1);
    tick(0, 0, 0, 1, 0, 1);
    chk("flush_cnt", 64'(flush_cnt), 64'd2);
    tick(0, 0, 0, 1, 0, 0);
`endif
    tick(0, 0, 0, 1, 0, 0);
    chk("idle_instr", 64'(out_instr), 64'hFC000000);
    for (int i = 0; i < 8; i++) begin
      tick(1, 32'h100 + i, 4 * i + 4, 1, 0, 0);
      chk("stream_instr", 64'(out_instr), 64'h100 + i);
      chk("stream_pc", 64'(out_pc), 64'(4 * i + 4));
      chk("stream_rdy", 64'(in_ready), 64'd1);
    end
    tick(0, 0, 0, 1, 0, 0);
    chk("drain_valid", 64'(out_valid), 64'd0);
    tick(1, 32'hA0, 32'h10, 0, 0, 0);
    tick(1, 32'hB0, 32'h14, 0, 0, 0);
    chk("bp_rdy", 64'(in_ready), 64'd0);
    chk("bp_a", 64'(out_instr), 64'hA0);
    tick(1, 32'hC0, 32'h18, 0, 0, 0);
    chk("bp_a_held", 64'(out_instr), 64'hA0);
    tick(0, 0, 0, 1, 0, 0);
    chk("bp_b", 64'(out_instr), 64'hB0);
    chk("bp_b_pc", 64'(out_pc), 64'h14);
    chk("bp_rdy_back", 64'(in_ready), 64'd1);
    tick(0, 0, 0, 1, 0, 0);
    chk("bp_empty", 64'(out_valid), 64'd0);
    tick(1, 32'h200, 32'h40, 1, 0, 0);
    tick(1, 32'h201, 32'h44, 1, 1, 0);
    chk("hold1", 64'(out_instr), 64'h200);
    tick(1, 32'h202, 32'h48, 0, 1, 0);
    chk("hold2", 64'(out_instr), 64'h200);
    tick(0, 0, 0, 1, 1, 0);
    chk("hold3", 64'(out_instr), 64'h200);
    tick(0, 0, 0, 1, 0, 0);
    chk("hold_resume", 64'(out_instr), 64'h201);
    tick(0, 0, 0, 1, 0, 0);
    tick(1, 32'h300, 32'h60, 0, 0, 0);
    tick(1, 32'h301, 32'h64, 0, 0, 0);
    tick(1, 32'h302, 32'h68, 0, 1, 1);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_instr", 64'(out_instr), 64'hFC000000);
    chk("flush_pc", 64'(out_pc), 64'd0);
    chk("flush_rdy", 64'(in_ready), 64'd1);
    tick(1, 32'h310, 32'h70, 1, 0, 1);
    tick(0, 0, 0, 1, 0, 0);
    chk("flushed_gone", 64'(out_valid), 64'd0);
    for (int i = 0; i < 60; i++)
      tick(1'($urandom), 32'h400 + i, 32'h100 + 4 * i, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 15) == 0));
    tick(1, 32'h500, 32'h80, 0, 0, 0);
    tick(1, 32'h501, 32'h84, 0, 0, 0);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_instr", 64'(out_instr), 64'hFC000000);
    chk("arst_pc", 64'(out_pc), 64'd0);
    chk("arst_rdy", 64'(in_ready), 64'd1);
    #10 rst = 0;
    tick(0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
